// File: rtl/bundle_issue_scheduler.sv
// Fetch-to-parser bundle FIFO with single-issue pulse, major-ID assignment and flush/refill hold.
// Optional performance counters are built only when BUNDLE_SCHED_PERF_EN is defined.
module bundle_issue_scheduler #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int bundleSize              = 4 * instructionWidth,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int QueueDepth              = 4,
    parameter int QueuePtrWidth           = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               fetchValid_i,
    output logic                               fetchReady_o,
    input  logic [bundleSize-1:0]              bundle_i,
    input  logic [addressWidth-1:0]            bundleAddress_i,
    input  logic [1:0]                         bundleLen_i,
    input  logic [PidSize-1:0]                 bundlePid_i,
    input  logic [TidSize-1:0]                 bundleTid_i,
    input  logic                               decodeStall_i,
    output logic                               parserEnable_o,
    output logic [bundleSize-1:0]              bundle_o,
    output logic [addressWidth-1:0]            bundleAddress_o,
    output logic [1:0]                         bundleLen_o,
    output logic [PidSize-1:0]                 bundlePid_o,
    output logic [TidSize-1:0]                 bundleTid_o,
    output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
    output logic [QueuePtrWidth:0]             occupancy_o,
    output logic [31:0]                        perfStallCycles_o,
    output logic [31:0]                        perfIssuedInstrs_o
);

    // state      | meaning
    // RUN        | normal accept/issue
    // FLUSH_HOLD | one-cycle refill hold after a flush edge; no accept, no issue
    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_HOLD = 1'b1
    } state_t;

    localparam logic [QueuePtrWidth:0] FullCount = (QueuePtrWidth + 1)'(QueueDepth);

    state_t state, state_next;

    logic [bundleSize-1:0]    mem_bundle [QueueDepth];
    logic [addressWidth-1:0]  mem_addr   [QueueDepth];
    logic [1:0]               mem_len    [QueueDepth];
    logic [PidSize-1:0]       mem_pid    [QueueDepth];
    logic [TidSize-1:0]       mem_tid    [QueueDepth];

    logic [QueuePtrWidth-1:0] head, tail;
    logic [QueuePtrWidth:0]   count;
    logic [instructionCounterWidth-1:0] maj_ctr;
    logic [1:0]               head_len;

    logic run, fetch_ready, do_push, do_issue;

    assign head_len     = mem_len[head];
    assign occupancy_o  = count;
    assign fetchReady_o = fetch_ready;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = RUN;
        run         = 1'b0;
        fetch_ready = 1'b0;
        do_push     = 1'b0;
        do_issue    = 1'b0;
        if (flush_i) begin
            state_next = FLUSH_HOLD;
        end
        if (state == RUN) begin
            run = 1'b1;
        end
        fetch_ready = run && (count != FullCount) && !flush_i;
        do_push     = fetch_ready && fetchValid_i;
        // pop decision uses start-of-cycle occupancy, so a same-cycle push cannot bypass
        do_issue    = run && (count != '0) && !decodeStall_i && !flush_i;
    end

    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_bundle[tail] <= bundle_i;
            mem_addr[tail]   <= bundleAddress_i;
            mem_len[tail]    <= bundleLen_i;
            mem_pid[tail]    <= bundlePid_i;
            mem_tid[tail]    <= bundleTid_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_issue) begin
                head <= head + 1'b1;
            end
            if (do_push && !do_issue) begin
                count <= count + 1'b1;
            end else if (!do_push && do_issue) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            parserEnable_o     <= 1'b0;
            bundle_o           <= '0;
            bundleAddress_o    <= '0;
            bundleLen_o        <= '0;
            bundlePid_o        <= '0;
            bundleTid_o        <= '0;
            bundleStartMajId_o <= '0;
            maj_ctr            <= '0;
        end else if (do_issue) begin
            parserEnable_o     <= 1'b1;
            bundle_o           <= mem_bundle[head];
            bundleAddress_o    <= mem_addr[head];
            bundleLen_o        <= head_len;
            bundlePid_o        <= mem_pid[head];
            bundleTid_o        <= mem_tid[head];
            bundleStartMajId_o <= maj_ctr;
            // flush never touches the counter, keeping IDs unique across flushes
            maj_ctr            <= maj_ctr + instructionCounterWidth'(head_len)
                                          + instructionCounterWidth'(1);
        end else begin
            parserEnable_o <= 1'b0;
        end
    end

`ifdef BUNDLE_SCHED_PERF_EN
    logic [31:0] stall_cnt, instr_cnt;
    logic [32:0] instr_sum;

    assign instr_sum = {1'b0, instr_cnt} + 33'(head_len) + 33'd1;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (run && (count != '0) && decodeStall_i && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (do_issue) begin
                instr_cnt <= instr_sum[32] ? 32'hFFFF_FFFF : instr_sum[31:0];
            end
        end
    end

    assign perfStallCycles_o  = stall_cnt;
    assign perfIssuedInstrs_o = instr_cnt;
`else
    assign perfStallCycles_o  = '0;
    assign perfIssuedInstrs_o = '0;
`endif

endmodule
